// File: rtl/move_display_sequencer.sv
// Buffers cube moves in a small FIFO and presents them one at a time as face/modifier
// display codes, each held for a dwell time and followed by a blank gap.
module move_display_sequencer #(
    parameter int DEPTH        = 8,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int GAP_CYCLES   = 5_000_000
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET_N,
    input  logic                       move_valid,
    input  logic [2:0]                 move_face,
    input  logic [1:0]                 move_dir,
    output logic                       move_ready,
    input  logic                       clear,
    output logic [3:0]                 face_code,
    output logic [3:0]                 mod_code,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       drop_err
);

    localparam int PW   = $clog2(DEPTH);
    localparam int PCW  = $clog2(DEPTH + 1);
    localparam int CNTW = $clog2(((DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES) + 1);
    localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL_CYCLES - 1);
    localparam logic [CNTW-1:0] GAP_LAST   = CNTW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PCW-1:0]  FULL_CNT   = PCW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PCW-1:0]  pending_q, pending_d;
    logic [3:0]      face_q, face_d;
    logic [3:0]      mod_q, mod_d;
    logic            drop_q, drop_d;
    logic [4:0]      mem_q [DEPTH];

    logic full, empty, accept, legal, push, pop;
    logic [4:0] head;

    assign full       = (pending_q == FULL_CNT);
    assign empty      = (pending_q == '0);
    assign move_ready = !full && !clear;
    assign accept     = move_valid && move_ready;
    assign legal      = (move_face <= 3'd5) && (move_dir != 2'd3);
    assign push       = accept && legal;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        state_d = ST_SHOW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ST_SHOW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // clear wins over any pop the sequencer would otherwise take
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pop     = 1'b0;
        end
    end

    always_comb begin
        face_d    = face_q;
        mod_d     = mod_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        pending_d = pending_q;
        drop_d    = accept && !legal;
        if (pop) begin
            face_d   = {1'b0, head[4:2]};
            rd_ptr_d = rd_ptr_q + PW'(1);
            case (head[1:0])
                2'd0:    mod_d = 4'hB;
                2'd1:    mod_d = 4'hC;
                default: mod_d = 4'hD;
            endcase
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   pending_d = pending_q + PCW'(1);
            2'b01:   pending_d = pending_q - PCW'(1);
            default: pending_d = pending_q;
        endcase
        if (clear) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            pending_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            pending_q <= '0;
            face_q    <= '0;
            mod_q     <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            pending_q <= pending_d;
            face_q    <= face_d;
            mod_q     <= mod_d;
            drop_q    <= drop_d;
        end
    end

    // Storage needs no reset: pointers and pending define what is valid.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {move_face, move_dir};
        end
    end

    always_comb begin
        face_code = 4'hA;
        mod_code  = 4'hF;
        busy      = 1'b0;
        case (state_q)
            ST_SHOW: begin
                face_code = face_q;
                mod_code  = mod_q;
                busy      = 1'b1;
            end
            ST_GAP: begin
                face_code = 4'hF;
                mod_code  = 4'hF;
                busy      = 1'b1;
            end
            default: begin
                face_code = 4'hA;
                mod_code  = 4'hF;
                busy      = 1'b0;
            end
        endcase
    end

    assign pending  = pending_q;
    assign drop_err = drop_q;

endmodule
